// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package div_pkg;

  localparam int unsigned DefWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = div_pkg::DefWidth
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_in, din};
    q_bit   = (shifted >= {2'b00, divisor});
    // Whenever the subtract succeeds the true difference is below the divisor, so it fits.
    diff    = shifted[WIDTH:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle 2W/W unsigned divider: error checks at start, then one quotient bit per cycle.
module sequential_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] dividend_hi;
  logic             last_iter;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .din     (low_q[WIDTH-1]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    quo_next    = (quo_q << 1) | WIDTH'(step_q);
    dividend_hi = dividend[2*WIDTH-1:WIDTH];
    last_iter   = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      low_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            divisor_q   <= divisor;
            rem_q       <= {1'b0, dividend_hi};
            low_q       <= dividend[WIDTH-1:0];
            quo_q       <= '0;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              state_q     <= StDone;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else if (dividend_hi >= divisor) begin
              // Upper half already >= divisor: the quotient cannot fit in WIDTH bits.
              state_q   <= StDone;
              done      <= 1'b1;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
            end
          end
        end
        StRun: begin
          rem_q <= step_rem;
          low_q <= low_q << 1;
          quo_q <= quo_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= quo_next;
            remainder <= step_rem[WIDTH-1:0];
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (WIDTH=8) with hand-computed expected results.
module tb_sequential_divider;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           overflow;

  int total;
  int bad;

  sequential_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check timing, results and flags.
  task automatic run_op(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input int exp_cyc, input logic exp_dbz, input logic exp_ovf);
    int cyc;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    if (exp_cyc > 1) begin
      check({tag, ".busy1"}, 32'(busy), 32'd1);
      check({tag, ".flags_clear"}, {30'd0, div_by_zero, overflow}, 32'd0);
    end
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, ".quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, ".remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".hold_q"}, 32'(quotient), 32'(exp_q));
    check({tag, ".hold_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, exp_dbz, exp_ovf});
  endtask

  initial begin
    int cyc;
    int done_seen;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset.outs", {quotient, remainder, 12'd0, busy, done, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("small", 16'h0008, 8'h02, 8'h04, 8'h00, 9, 1'b0, 1'b0);
    run_op("rem5", 16'h0B69, 8'hF3, 8'h0C, 8'h05, 9, 1'b0, 1'b0);
    run_op("exact", 16'h0B64, 8'hF3, 8'h0C, 8'h00, 9, 1'b0, 1'b0);
    run_op("dbz", 16'h1234, 8'h00, 8'hFF, 8'h00, 1, 1'b1, 1'b0);
    run_op("ovf", 16'h0200, 8'h02, 8'hFF, 8'h00, 1, 1'b0, 1'b1);
    run_op("maxq", 16'h01FF, 8'h02, 8'hFF, 8'h01, 9, 1'b0, 1'b0);
    run_op("ovf_eq", 16'hFF00, 8'hFF, 8'hFF, 8'h00, 1, 1'b0, 1'b1);
    run_op("maxrem", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 9, 1'b0, 1'b0);

    // Start pulsed mid-RUN with different operands must be ignored.
    dividend = 16'h0064;
    divisor  = 8'h0A;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dividend = 16'h0008;
    divisor  = 8'h01;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 4;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check("ignore.cycle", 32'(cyc), 32'd9);
    check("ignore.quotient", 32'(quotient), 32'h0A);
    check("ignore.remainder", 32'(remainder), 32'h00);
    tick();

    // Reset mid-RUN: outputs clear without a clock edge, and no done follows.
    dividend = 16'h0B69;
    divisor  = 8'hF3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort.outs", {quotient, remainder, 12'd0, busy, done, div_by_zero, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    run_op("after_rst", 16'h01FF, 8'h02, 8'hFF, 8'h01, 9, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the divisor, quotient and remainder width; the dividend is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, 2*WIDTH, numerator; sampled on the accepted start.
REQ-006 SHALL have port divisor, input, WIDTH, denominator; sampled on the accepted start.
REQ-007 SHALL have port quotient, output, WIDTH, registered result.
REQ-008 SHALL have port remainder, output, WIDTH, registered result.
REQ-009 SHALL have port busy, output, 1, high while in RUN.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-011 SHALL have port div_by_zero, output, 1, error flag, valid with done.
REQ-012 SHALL have port overflow, output, 1, flag for a quotient too wide for WIDTH bits, valid with done.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE; reset enters IDLE.
REQ-014 SHALL accept start only in IDLE; in that case dividend and divisor are latched internally and error checks are made on the latched values.
REQ-015 SHALL, when an accepted divisor is 0, go IDLE->DONE with div_by_zero=1, overflow=0, quotient all-ones and remainder 0.
REQ-016 SHALL, when the divisor is nonzero and dividend[2W-1:W] >= divisor, go IDLE->DONE with overflow=1, div_by_zero=0, quotient all-ones and remainder 0.
REQ-017 SHALL otherwise go IDLE->RUN and perform restoring shift-subtract, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-018 SHALL hold the partial remainder in WIDTH+1 bits so the trial subtract never loses a carry.
REQ-019 SHALL go RUN->DONE after the WIDTH-th iteration and DONE->IDLE unconditionally on the next cycle.
REQ-020 SHALL assert done for exactly one cycle, while in DONE, with the result and flags updated in the same cycle.
REQ-021 SHALL, for a normal division, assert done WIDTH+1 cycles after the edge that accepted start; for an error case, 1 cycle after it.
REQ-022 SHALL hold quotient, remainder, div_by_zero and overflow stable from done until the edge of the next accepted start, at which point the flags clear.
REQ-023 SHALL ignore start while in RUN or DONE; no queuing.
REQ-024 SHALL have busy=1 exactly in RUN.
REQ-025 SHALL, for every normal result, satisfy quotient*divisor + remainder = dividend and remainder < divisor.
REQ-026 SHALL accept a start in the cycle after DONE, giving a minimum spacing of WIDTH+2 cycles between back-to-back operations.

Reset
REQ-027 SHALL, while rst is asserted, immediately force the FSM to IDLE and drive quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and overflow=0, independent of clk.
REQ-028 SHALL abort a division in progress on reset with no done pulse; the first start after rst deasserts is processed normally.

Structure
REQ-029 SHALL place the FSM state enumeration and the default WIDTH constant in shared package div_pkg.
REQ-030 SHALL use one combinational sub-module, div_step, which shifts the next dividend bit into the partial remainder, trial-subtracts the divisor, and returns the new remainder and quotient bit; the top module holds the FSM, iteration counter and registers.
REQ-031 SHALL use an iteration counter of clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-032 SHALL verify: dividend=0x0008, divisor=0x02 -> quotient=0x04, remainder=0x00, done at cycle 9, no flags.
REQ-033 SHALL verify: dividend=0x0B69, divisor=0xF3 -> quotient=0x0C, remainder=0x05; also 0x0B64/0xF3 -> quotient=0x0C, remainder=0x00.
REQ-034 SHALL verify: divisor=0x00, any dividend -> done at cycle 1, div_by_zero=1, quotient=0xFF, remainder=0x00.
REQ-035 SHALL verify: dividend=0x0200, divisor=0x02 -> done at cycle 1, overflow=1, quotient=0xFF; then 0x01FF/0x02 -> quotient=0xFF, remainder=0x01, no overflow.
REQ-036 SHALL verify: start pulsed during RUN with other operands -> ignored, first result unchanged; rst asserted mid-RUN -> outputs zero at once, no done, next start correct.
